cardinal_mc_ctrl: RTL and testbench

Sequencer for the multi-cycle vector ALU operations VDIV, VMOD and VSQRT in the cardinal processor pipeline. It sits beside the ID/EX boundary. It detects a multi-cycle op in ID, freezes the pipeline, and times the iterative arithmetic unit with a width-dependent latency. It then releases the pipeline with a one-cycle result strobe that tags the destination register. It replaces the fixed two-cycle stall counter in the core with a parameterised, abortable FSM and a saturating stall-cycle counter.

---
 rtl/cardinal_mc_ctrl.sv | 126 ++++++++++++
 tb/tb_cardinal_mc_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cardinal_mc_ctrl.sv
// Multi-cycle sequencer for VDIV/VMOD/VSQRT: freezes the pipeline, times the
// iterative unit with a width-dependent latency and strobes the tagged result.
module cardinal_mc_ctrl #(
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned SQRT_LAT = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Issue,
  input  logic [5:0]  Funct,
  input  logic [1:0]  WW,
  input  logic [4:0]  rD_Addr,
  input  logic        Kill,
  output logic        Stall,
  output logic        Unit_Start,
  output logic [1:0]  Unit_Sel,
  output logic        Result_Valid,
  output logic [4:0]  Result_rD,
  output logic [1:0]  Result_WW,
  output logic [15:0] Busy_Cycles
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned BusyW = 16;

  localparam logic [5:0] FunctVdiv  = 6'b001110;
  localparam logic [5:0] FunctVmod  = 6'b001111;
  localparam logic [5:0] FunctVsqrt = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        ww_q, ww_d;
  logic              start_q, start_d;
  logic [BusyW-1:0]  busy_q, busy_d;

  logic              is_div, is_mod, is_sqrt, mc_hit;
  logic [1:0]        hit_sel;
  logic [CntW-1:0]   lat;

  // Decode of the ID instruction; latency wraps in 4 bits by construction.
  always_comb begin
    is_div  = (Funct == FunctVdiv);
    is_mod  = (Funct == FunctVmod);
    is_sqrt = (Funct == FunctVsqrt);
    mc_hit  = Issue && (is_div || is_mod || is_sqrt);
    hit_sel = is_sqrt ? 2'b10 : (is_mod ? 2'b01 : 2'b00);
    lat     = (is_sqrt ? CntW'(SQRT_LAT) : CntW'(DIV_LAT)) + CntW'(WW);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    ww_d    = ww_q;
    start_d = 1'b0;
    Stall   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (mc_hit) begin
          Stall   = 1'b1;
          start_d = 1'b1;
          sel_d   = hit_sel;
          rd_d    = rD_Addr;
          ww_d    = WW;
          cnt_d   = lat - CntW'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (Kill) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (Stall && (busy_q != {BusyW{1'b1}})) begin
      busy_d = busy_q + BusyW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      ww_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      ww_q    <= ww_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign Unit_Start   = start_q;
  assign Unit_Sel     = sel_q;
  assign Result_Valid = (state_q == DONE);
  assign Result_rD    = rd_q;
  assign Result_WW    = ww_q;
  assign Busy_Cycles  = busy_q;

endmodule

// File: tb/tb_cardinal_mc_ctrl.sv
// Directed bench for cardinal_mc_ctrl: per-cycle checks of stall, start and
// result strobes across normal, killed, back-to-back, reset and saturation cases.
module tb_cardinal_mc_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, Issue, Kill;
  logic [5:0]  Funct;
  logic [1:0]  WW;
  logic [4:0]  rD_Addr;
  logic        Stall, Unit_Start, Result_Valid;
  logic [1:0]  Unit_Sel, Result_WW;
  logic [4:0]  Result_rD;
  logic [15:0] Busy_Cycles;

  int n_cmp = 0;
  int n_err = 0;
  int exp_busy = 0;

  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;
  localparam logic [5:0] VSQRT = 6'b010010;
  localparam logic [5:0] VADD  = 6'b000110;

  cardinal_mc_ctrl #(.DIV_LAT(8), .SQRT_LAT(6)) dut (
    .Clock(Clock), .Reset(Reset), .Issue(Issue), .Funct(Funct), .WW(WW),
    .rD_Addr(rD_Addr), .Kill(Kill), .Stall(Stall), .Unit_Start(Unit_Start),
    .Unit_Sel(Unit_Sel), .Result_Valid(Result_Valid), .Result_rD(Result_rD),
    .Result_WW(Result_WW), .Busy_Cycles(Busy_Cycles)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op at cycle 0 and hold Issue through DONE; L is hand-computed.
  task automatic run_op(input logic [5:0] f, input logic [1:0] w, input logic [4:0] rd,
                        input int lat, input logic [1:0] sel);
    Issue = 1'b1; Funct = f; WW = w; rD_Addr = rd;
    for (int c = 0; c <= lat + 1; c++) begin
      #1;
      chk($sformatf("stall_c%0d", c), Stall, (c <= lat));
      chk($sformatf("start_c%0d", c), Unit_Start, (c == 1));
      chk($sformatf("rv_c%0d", c), Result_Valid, (c == lat + 1));
      if (c == 1) chk("sel", Unit_Sel, sel);
      if (c == lat + 1) begin
        chk("res_rd", Result_rD, rd);
        chk("res_ww", Result_WW, w);
        exp_busy += lat + 1;
        chk("busy_done", Busy_Cycles, exp_busy);
      end
      tick();
    end
    Issue = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Issue = 1'b0; Kill = 1'b0; Funct = '0; WW = '0; rD_Addr = '0;
    tick(); tick();
    chk("rst_stall", Stall, 0);
    chk("rst_start", Unit_Start, 0);
    chk("rst_sel", Unit_Sel, 0);
    chk("rst_rv", Result_Valid, 0);
    chk("rst_rd", Result_rD, 0);
    chk("rst_ww", Result_WW, 0);
    chk("rst_busy", Busy_Cycles, 0);
    Reset = 1'b0;

    // VDIV, 8-bit: L = 8
    run_op(VDIV, 2'b00, 5'd5, 8, 2'b00);
    tick();
    // VSQRT, 64-bit: L = 6 + 3 = 9
    run_op(VSQRT, 2'b11, 5'd12, 9, 2'b10);
    tick();

    // Non-multi-cycle op is ignored
    Issue = 1'b1; Funct = VADD; WW = 2'b10; rD_Addr = 5'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("vadd_stall", Stall, 0);
      chk("vadd_start", Unit_Start, 0);
      chk("vadd_rv", Result_Valid, 0);
      tick();
    end
    chk("vadd_busy", Busy_Cycles, exp_busy);
    Issue = 1'b0;
    tick();

    // VMOD 16-bit killed at BUSY cycle 4, then VDIV accepted at cycle 5
    Issue = 1'b1; Funct = VMOD; WW = 2'b01; rD_Addr = 5'd9;
    for (int c = 0; c <= 4; c++) begin
      #1;
      chk("kill_stall", Stall, 1);
      chk("kill_rv", Result_Valid, 0);
      if (c == 1) chk("kill_sel", Unit_Sel, 2'b01);
      if (c == 4) Kill = 1'b1;
      tick();
    end
    Kill = 1'b0; Issue = 1'b0;
    #1;
    chk("kill_stall_low", Stall, 0);
    chk("kill_rv5", Result_Valid, 0);
    exp_busy += 5;
    chk("kill_busy", Busy_Cycles, exp_busy);
    run_op(VDIV, 2'b00, 5'd7, 8, 2'b00);
    tick();

    // Back-to-back VDIVs with Issue held through DONE
    Issue = 1'b1; Funct = VDIV; WW = 2'b00; rD_Addr = 5'd3;
    for (int c = 0; c <= 19; c++) begin
      if (c == 10) rD_Addr = 5'd4;
      #1;
      chk($sformatf("b2b_stall_c%0d", c), Stall, (c <= 8) || (c >= 10 && c <= 18));
      chk($sformatf("b2b_start_c%0d", c), Unit_Start, (c == 1) || (c == 11));
      chk($sformatf("b2b_rv_c%0d", c), Result_Valid, (c == 9) || (c == 19));
      if (c == 9)  chk("b2b_rd1", Result_rD, 5'd3);
      if (c == 19) chk("b2b_rd2", Result_rD, 5'd4);
      tick();
    end
    Issue = 1'b0;
    exp_busy += 18;
    chk("b2b_busy", Busy_Cycles, exp_busy);

    // Reset at BUSY cycle 3 of a VSQRT
    Issue = 1'b1; Funct = VSQRT; WW = 2'b00; rD_Addr = 5'd9;
    tick(); tick(); tick();
    Reset = 1'b1; Issue = 1'b0;
    tick();
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_start", Unit_Start, 0);
    chk("mid_rst_sel", Unit_Sel, 0);
    chk("mid_rst_rv", Result_Valid, 0);
    chk("mid_rst_rd", Result_rD, 0);
    chk("mid_rst_ww", Result_WW, 0);
    chk("mid_rst_busy", Busy_Cycles, 0);
    Reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("mid_rst_norv", Result_Valid, 0);
    end

    // Saturation: hit held with Kill keeps Stall high every cycle
    Issue = 1'b1; Funct = VDIV; Kill = 1'b1;
    repeat (65534) tick();
    chk("sat_pre", Busy_Cycles, 16'hFFFE);
    tick();
    chk("sat_hit", Busy_Cycles, 16'hFFFF);
    repeat (4465) tick();
    chk("sat_stall", Stall, 1);
    chk("sat_hold", Busy_Cycles, 16'hFFFF);
    Issue = 1'b0; Kill = 1'b0;
    tick(); tick();
    chk("sat_idle", Busy_Cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
